ahbl_sram_ctrl: RTL and testbench
=================================

# ahbl_sram_ctrl

AHB-Lite responder that sits on the system bus as the SRAM slave and drives a single-port synchronous SRAM macro (CS, per-byte WEN, 1-cycle read latency). It is the target-side counterpart of the CPU's AHB-Lite initiator. Reads and writes complete with zero wait states. A one-entry write-stash buffer with read-merge resolves SRAM port conflicts, and illegal transfers get the two-cycle AHB ERROR response.

## Interface
- AW, 12, SRAM word-address width; capacity is 2^AW words of 32 bits.
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address; bits [AW+1:0] are used.
- HTRANS  in  2  only NONSEQ (2) and SEQ (3) start transfers.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; values above 2 are illegal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; an address phase is accepted only when it is 1.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data, valid in the read data phase.
- SRAMRDATA  in  32  SRAM read data, valid the cycle after a read strobe.
- SRAMWEN  out  4  per-byte write enables.
- SRAMWDATA  out  32  SRAM write data.
- SRAMCS0  out  1  SRAM chip select.
- SRAMADDR  out  AW  SRAM word address.

## Operation
- **Accept.** acc = HSEL & HREADY & HTRANS[1].
- **Illegal transfer.** An accepted transfer is illegal if HSIZE > 2, a halfword has HADDR[0] = 1, or a word has HADDR[1:0] ≠ 0.
  - Illegal transfers never touch the SRAM.
- **Byte mask.**
  - Byte: 1 << HADDR[1:0].
  - Half: 4'b0011 if HADDR[1] = 0, else 4'b1100.
  - Word: 4'b1111.
- **Registered address-phase info.** dp_rd, dp_wr, dp_addr, dp_mask.
- **SRAM port arbitration (combinational, one user per cycle), highest priority first:**
  - (1) Legal read address phase: CS = 1, WEN = 0, ADDR = HADDR[AW+1:2].
  - (2) Write data phase (dp_wr): CS = 1, WEN = dp_mask, ADDR = dp_addr, WDATA = HWDATA.
  - (3) Stash drain (stash_v): CS = 1, WEN = stash_mask, ADDR = stash_addr, WDATA = stash_data; stash_v clears at the edge.
  - Otherwise CS = 0, WEN = 0.
- **Stash.** When dp_wr coincides with (1), store {dp_addr, dp_mask, HWDATA} into the stash and set stash_v.
  - Invariant: stash_v is 0 whenever a stash is written. The preceding write address phase cycle is free, so it drains the stash. Verification must assert this.
- **Read merge.** In a read data phase, HRDATA byte i = stash_data byte i if stash_v & stash_addr == dp_addr & stash_mask[i]; otherwise SRAMRDATA byte i.
  - Outside a read data phase HRDATA = 0.
- **FSM.** States OK, ERR1, ERR2.
  - OK → ERR1 on acc of an illegal transfer.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → OK, or → ERR1 if a new illegal transfer is accepted.
  - Outputs: OK gives HREADYOUT = 1, HRESP = 0. ERR1 gives HREADYOUT = 0, HRESP = 1. ERR2 gives HREADYOUT = 1, HRESP = 1.
  - No address phase is accepted in ERR1, since the bus HREADY is low.
- **Reset.**
  - State = OK; dp_rd, dp_wr and stash_v cleared.
  - Outputs: HREADYOUT = 1, HRESP = 0, HRDATA = 0, SRAMCS0 = 0, SRAMWEN = 0.
  - Reset mid-transfer discards any pending write, including a stashed one.

## Timing
- **Read.** The address phase in cycle N strobes the SRAM in cycle N; HRDATA is valid in cycle N+1 with HREADYOUT = 1, so zero wait states.
- **Write.** The address phase is in cycle N, data in N+1. The SRAM is written at the end of N+1, or later via the stash; no wait states.
- **Error.** Two data-phase cycles (ERR1, ERR2).
- **Back-to-back and IDLE/BUSY.**
  - Back-to-back reads and writes in any mix sustain one transfer per cycle.
  - IDLE/BUSY, or HSEL = 0, gives an OKAY zero-wait data phase with no SRAM activity, except that a stash drain may occur.
- **Read-after-write to the same word.** Returns merged (new) data, regardless of whether the write is stashed or already committed.

## Structure
- **Package ahbl_pkg.**
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HSIZE codes and HRESP codes.
  - The FSM state enum.
  - A byte-mask function (size, addr[1:0]) → 4 bits, plus a legality function.
- **Sub-module ahbl_sram_wbuf.** Holds the stash registers, the stash/drain control and the read-merge mux.
- **Top.** The phase registers, the FSM and the port arbitration.

## Test plan
- Write word 0x11223344 to 0x0, then read 0x0 → HRDATA 0x11223344; every transfer has HREADYOUT = 1.
- Write byte 0xAB to 0x5, with its data phase overlapping a read address phase to 0x4 → stash_v = 1. The read returns 0x????AB?? merged: byte 1 = 0xAB, other bytes old SRAM contents. The next free cycle shows CS = 1, WEN = 4'b0010.
- Write half 0xBEEF to 0x2, then read 0x0 the next cycle, then read 0x0 again → both return 0xBEEF in [31:16].
- Word access to 0x2 → HREADYOUT 0 then 1, with HRESP = 1 for both cycles; SRAMCS0 stays 0; the SRAM is unchanged.
- HSIZE = 3 write immediately followed by a legal read → ERROR sequence, then the read completes with OKAY and the correct data.
- Assert HRESETn low while the stash is valid → SRAMCS0 = 0, HREADYOUT = 1 and stash_v = 0 immediately; the stashed word is never written.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite codes, SRAM-slave FSM states and
// byte-lane helpers for the SRAM controller.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [3:0] byte_mask(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << a;
      HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic size_legal(
    input logic [2:0] size,
    input logic [1:0] a
  );
    return (size == HSIZE_BYTE)
      | ((size == HSIZE_HALF) & ~a[0])
      | ((size == HSIZE_WORD) & (a == 2'b00));
  endfunction

endpackage

// File: rtl/ahbl_sram_wbuf.sv
// One-entry write stash: parks a write that lost the SRAM port
// to a read, drains it on the next free cycle, merges into reads.
module ahbl_sram_wbuf
  import ahbl_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_ap,
  input  logic          dp_wr,
  input  logic          dp_rd,
  input  logic [AW-1:0] dp_addr,
  input  logic [3:0]    dp_mask,
  input  logic [31:0]   wdata,
  input  logic [31:0]   sram_rdata,
  output logic          stash_v,
  output logic          drain,
  output logic [AW-1:0] stash_addr,
  output logic [3:0]    stash_mask,
  output logic [31:0]   stash_data,
  output logic [31:0]   rdata
);

  logic stash_we;
  logic hit;

  assign stash_we = dp_wr & rd_ap;
  assign drain    = stash_v & ~rd_ap & ~dp_wr;
  assign hit      = stash_v & (stash_addr == dp_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stash_v    <= 1'b0;
      stash_addr <= '0;
      stash_mask <= '0;
      stash_data <= '0;
    end else if (stash_we) begin
      stash_v    <= 1'b1;
      stash_addr <= dp_addr;
      stash_mask <= dp_mask;
      stash_data <= wdata;
    end else if (drain) begin
      stash_v    <= 1'b0;
    end
  end

  // Stashed bytes are newer than anything the SRAM returns
  always_comb begin
    rdata = '0;
    if (dp_rd) begin
      for (int i = 0; i < 4; i++) begin
        rdata[i*8 +: 8] = (hit & stash_mask[i])
          ? stash_data[i*8 +: 8]
          : sram_rdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// Zero-wait-state AHB-Lite SRAM responder with one-entry write
// stash and two-cycle ERROR response for illegal transfers.
module ahbl_sram_ctrl
  import ahbl_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-1:0] SRAMADDR
);

  state_e state, state_nx;

  logic          acc, legal, rd_ap, wr_ap, bad;
  logic          dp_rd, dp_wr;
  logic [AW-1:0] dp_addr, ap_addr;
  logic [3:0]    dp_mask;
  logic          stash_v, drain, wr_go;
  logic [AW-1:0] stash_addr;
  logic [3:0]    stash_mask;
  logic [31:0]   stash_data;
  logic          unused_ok;

  assign unused_ok = ^{HADDR[31:AW+2], HTRANS[0]};

  // Gating with reset keeps the SRAM idle while reset is held
  assign acc     = HRESETn & HSEL & HREADY & HTRANS[1];
  assign legal   = size_legal(HSIZE, HADDR[1:0]);
  assign rd_ap   = acc & legal & ~HWRITE;
  assign wr_ap   = acc & legal & HWRITE;
  assign bad     = acc & ~legal;
  assign ap_addr = HADDR[AW+1:2];
  assign wr_go   = dp_wr & ~rd_ap;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_OK;
      dp_rd   <= 1'b0;
      dp_wr   <= 1'b0;
      dp_addr <= '0;
      dp_mask <= '0;
    end else begin
      state <= state_nx;
      dp_rd <= rd_ap;
      dp_wr <= wr_ap;
      if (rd_ap | wr_ap) begin
        dp_addr <= ap_addr;
        dp_mask <= byte_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_OK: begin
        if (bad) state_nx = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP    = HRESP_ERROR;
        state_nx = bad ? ST_ERR1 : ST_OK;
      end
      default: state_nx = ST_OK;
    endcase
  end

  always_comb begin
    SRAMCS0   = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = ap_addr;
    SRAMWDATA = HWDATA;
    unique case (1'b1)
      rd_ap: begin
        SRAMCS0 = 1'b1;
      end
      wr_go: begin
        SRAMCS0  = 1'b1;
        SRAMWEN  = dp_mask;
        SRAMADDR = dp_addr;
      end
      drain: begin
        SRAMCS0   = 1'b1;
        SRAMWEN   = stash_mask;
        SRAMADDR  = stash_addr;
        SRAMWDATA = stash_data;
      end
      default: ;
    endcase
  end

  ahbl_sram_wbuf #(.AW(AW)) u_wbuf (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .rd_ap      (rd_ap),
    .dp_wr      (dp_wr),
    .dp_rd      (dp_rd),
    .dp_addr    (dp_addr),
    .dp_mask    (dp_mask),
    .wdata      (HWDATA),
    .sram_rdata (SRAMRDATA),
    .stash_v    (stash_v),
    .drain      (drain),
    .stash_addr (stash_addr),
    .stash_mask (stash_mask),
    .stash_data (stash_data),
    .rdata      (HRDATA)
  );

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Bench for ahbl_sram_ctrl: directed vector table, stash/reset
// sequence, then random traffic against a byte-level memory model.
module tb_ahbl_sram_ctrl;
  import ahbl_pkg::*;

  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic          SRAMCS0;
  logic [AW-1:0] SRAMADDR;

  always #5 HCLK = ~HCLK;

  // single slave on the bus
  assign HREADY = HREADYOUT;

  ahbl_sram_ctrl #(.AW(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .SRAMRDATA (SRAMRDATA),
    .SRAMWEN   (SRAMWEN),
    .SRAMWDATA (SRAMWDATA),
    .SRAMCS0   (SRAMCS0),
    .SRAMADDR  (SRAMADDR)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM macro: 1-cycle read latency, per-byte write enables
  logic [31:0] mem [2**AW];
  logic        init_req = 1'b0;

  always @(posedge HCLK) begin
    if (init_req) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= init_word(i);
    end else if (SRAMCS0) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      for (int b = 0; b < 4; b++)
        if (SRAMWEN[b])
          mem[SRAMADDR][b*8 +: 8] <= SRAMWDATA[b*8 +: 8];
    end
  end

  // a stash must never overwrite a live stash
  always @(posedge HCLK) begin
    if (HRESETn && dut.u_wbuf.stash_we) begin
      total++;
      if (dut.u_wbuf.stash_v) begin
        bad++;
        $display("FAIL stash_overwrite got=1 want=0");
      end
    end
  end

  task automatic drive(input logic sel, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz,
                       input logic [31:0] ad,
                       input logic [31:0] wd);
    HSEL = sel; HTRANS = tr; HWRITE = wr;
    HSIZE = sz; HADDR = ad; HWDATA = wd;
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
    logic        cs;
    logic [3:0]  wen;
  } vec_t;

  function automatic vec_t mk(
    logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
    logic [31:0] ad, logic [31:0] wd, logic rdy, logic resp,
    logic [31:0] rd, logic cs, logic [3:0] wen);
    vec_t v;
    v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz;
    v.ad = ad; v.wd = wd; v.rdy = rdy; v.resp = resp;
    v.rd = rd; v.cs = cs; v.wen = wen;
    return v;
  endfunction

  function automatic vec_t idl(logic rdy, logic resp,
    logic [31:0] rd, logic cs, logic [3:0] wen);
    return mk(0, HTRANS_IDLE, 0, 0, 0, 0, rdy, resp, rd, cs, wen);
  endfunction

  // random-phase model: memory bytes 0..63 and the pending data phase
  typedef enum int {M_NONE, M_RD, M_WR, M_ERR1, M_ERR2} mk_e;

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
  } xfer_t;

  logic [7:0] gold [64];

  function automatic logic [31:0] gold_word(input int w);
    return {gold[4*w+3], gold[4*w+2], gold[4*w+1], gold[4*w]};
  endfunction

  function automatic bit m_legal(input int sz, input int a);
    return sz <= 2 && (a % (1 << sz)) == 0;
  endfunction

  function automatic xfer_t gen(input bit idle_only);
    xfer_t x;
    int k;
    k = $urandom_range(0, 9);
    x.wd  = $urandom;
    x.ad  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
    x.wr  = 1'($urandom_range(0, 1));
    x.sz  = ($urandom_range(0, 15) == 0)
          ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 7) != 0) begin
      if (x.sz == 3'd1) x.ad[0] = 1'b0;
      else if (x.sz == 3'd2) x.ad[1:0] = 2'b00;
    end
    x.sel = 1'b1;
    x.tr  = 2'($urandom_range(2, 3));
    if (idle_only || k < 2) x.tr = 2'($urandom_range(0, 1));
    else if (k == 2) x.sel = 1'b0;
    return x;
  endfunction

  vec_t        tbl[$];
  xfer_t       cur;
  mk_e         m_kind;
  int          m_addr, m_size;
  logic [31:0] m_wdata, w, e_rd;
  bit          held, acc, e_rdy, e_resp;

  initial begin
    HRESETn = 1'b0;
    drive(0, HTRANS_IDLE, 0, 0, 0, 0);
    init_req = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 init_req = 1'b0;
    @(negedge HCLK);
    check("rst_rdy",   0, 32'(HREADYOUT), 1);
    check("rst_resp",  0, 32'(HRESP), 0);
    check("rst_rdata", 0, HRDATA, 0);
    check("rst_cs",    0, 32'(SRAMCS0), 0);
    check("rst_wen",   0, 32'(SRAMWEN), 0);
    @(posedge HCLK); #1 HRESETn = 1'b1;

    // one row per clock: address phase, HWDATA, expected outputs
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 0, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 0, 32'h11223344,
                     1, 0, 0, 1, 0));
    tbl.push_back(idl(1, 0, 32'h11223344, 1, 4'hF));
    tbl.push_back(idl(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 5, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_SEQ, 0, HSIZE_WORD, 4, 32'h0000AB00,
                     1, 0, 0, 1, 0));
    tbl.push_back(idl(1, 0, 32'hC0DEAB01, 1, 4'b0010));
    tbl.push_back(idl(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 2, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 0, 32'hBEEF0000,
                     1, 0, 0, 1, 0));
    tbl.push_back(mk(1, HTRANS_SEQ, 0, HSIZE_WORD, 0, 0,
                     1, 0, 32'hBEEF3344, 1, 0));
    tbl.push_back(idl(1, 0, 32'hBEEF3344, 1, 4'b1100));
    tbl.push_back(idl(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 2, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 1, 0, 0, 0));
    tbl.push_back(idl(1, 1, 0, 0, 0));
    tbl.push_back(idl(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd3, 0, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 4, 32'h12345678,
                     0, 1, 0, 0, 0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 4, 0,
                     1, 1, 0, 1, 0));
    tbl.push_back(idl(1, 0, 32'hC0DEAB01, 0, 0));

    foreach (tbl[i]) begin
      @(posedge HCLK); #1;
      drive(tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].sz,
            tbl[i].ad, tbl[i].wd);
      @(negedge HCLK);
      check("vec_rdy",   i, 32'(HREADYOUT), 32'(tbl[i].rdy));
      check("vec_resp",  i, 32'(HRESP), 32'(tbl[i].resp));
      check("vec_rdata", i, HRDATA, tbl[i].rd);
      check("vec_cs",    i, 32'(SRAMCS0), 32'(tbl[i].cs));
      check("vec_wen",   i, 32'(SRAMWEN), 32'(tbl[i].wen));
    end
    check("mem_w0", 0, mem[0], 32'hBEEF3344);
    check("mem_w1", 1, mem[1], 32'hC0DEAB01);

    // reset while a write sits in the stash
    @(posedge HCLK); #1;
    drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h8, 0);
    @(posedge HCLK); #1;
    drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8, 32'hDEADBEEF);
    @(posedge HCLK); #1;
    drive(0, HTRANS_IDLE, 0, 0, 0, 0);
    check("pre_stash_v", 0, 32'(dut.u_wbuf.stash_v), 1);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_cs",    0, 32'(SRAMCS0), 0);
    check("mid_rst_rdy",   0, 32'(HREADYOUT), 1);
    check("mid_rst_rdata", 0, HRDATA, 0);
    check("mid_rst_stash", 0, 32'(dut.u_wbuf.stash_v), 0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("mem_w2_kept", 2, mem[2], init_word(2));

    // random traffic against the byte-level model
    @(posedge HCLK); #1 init_req = 1'b1;
    @(posedge HCLK); #1 init_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i / 4);
      gold[i] = w[(i % 4)*8 +: 8];
    end
    m_kind = M_NONE; held = 0;
    m_addr = 0; m_size = 0; m_wdata = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge HCLK); #1;
      if (!held) cur = gen(c >= 1990);
      drive(cur.sel, cur.tr, cur.wr, cur.sz, cur.ad,
            (m_kind == M_WR) ? m_wdata : $urandom);
      e_rdy  = (m_kind != M_ERR1);
      e_resp = (m_kind == M_ERR1 || m_kind == M_ERR2);
      e_rd   = (m_kind == M_RD) ? gold_word(m_addr / 4) : 0;
      @(negedge HCLK);
      check("rnd_rdy",   c, 32'(HREADYOUT), 32'(e_rdy));
      check("rnd_resp",  c, 32'(HRESP), 32'(e_resp));
      check("rnd_rdata", c, HRDATA, e_rd);
      if (m_kind == M_WR)
        for (int b = 0; b < (1 << m_size); b++)
          gold[m_addr + b] = m_wdata[((m_addr % 4) + b)*8 +: 8];
      acc  = e_rdy && cur.sel && cur.tr[1];
      held = !e_rdy;
      if (acc) begin
        m_addr  = int'(cur.ad[5:0]);
        m_size  = int'(cur.sz);
        m_wdata = cur.wd;
        if (!m_legal(m_size, m_addr)) m_kind = M_ERR1;
        else m_kind = cur.wr ? M_WR : M_RD;
      end else begin
        m_kind = (m_kind == M_ERR1) ? M_ERR2 : M_NONE;
      end
    end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    for (int i = 0; i < 16; i++)
      check("rnd_mem", i, mem[i], gold_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
